rf_write_arbiter: RTL and testbench
===================================

# rf_write_arbiter

Round-robin arbiter that shares the single register-file write port among `NREQ` writeback requesters (e.g. ALU writeback, load unit, multicycle mul/div). Each requester uses a valid/ready handshake. The block registers the winning request and drives the register file's `we`/`wa`/`wd` one cycle later. Writes that target register 0 are accepted but never issued.

## Interface
- `NREQ`, 2: number of requesters, legal range 2..4.
- `DW`, 32: write-data width.
- `AW`, 5: register-address width.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `wb_stall`  in  1  when high, no grants are made.
- `req_valid`  in  NREQ  request valid, one bit per requester.
- `req_wa`  in  NREQ*AW  destination register; requester i uses bits [i*AW +: AW].
- `req_wd`  in  NREQ*DW  write data; requester i uses bits [i*DW +: DW].
- `req_ready`  out  NREQ  one-hot or zero; grant to requester i in the current cycle.
- `we`  out  1  registered write enable to the register file.
- `wa`  out  AW  registered write address.
- `wd`  out  DW  registered write data.
- `conflict`  out  1  registered; high for one cycle after any cycle in which at least two requests were valid.

## Operation
- Handshake rules:
  - A transfer occurs on a rising edge when `req_valid[i] && req_ready[i]`.
  - Requesters hold `req_valid`, `req_wa` and `req_wd` stable until their transfer.
  - `req_ready` is combinational from `req_valid`, the rotating pointer `ptr`, `wb_stall` and `reset`. `req_ready` must never depend on `req_ready`.
- Arbitration:
  - Search starts at index `ptr` and wraps modulo NREQ. The first valid requester wins.
  - At most one `req_ready` bit is high per cycle.
  - No valid requests, `wb_stall`=1, or `reset`=1 gives `req_ready`=0.
- Pointer update:
  - On a transfer by requester k, `ptr` <= (k+1) mod NREQ.
  - Without a transfer, `ptr` holds.
- Output stage, on every rising edge:
  - If a transfer occurred: `wa`<=winner address, `wd`<=winner data, `we`<=(winner address != 0).
  - Otherwise: `we`<=0, and `wa`/`wd` hold their previous values.
- Register-0 writes still consume the grant and advance `ptr`. They do not raise `we`.
- `conflict` <= (popcount(`req_valid`) >= 2), sampled every cycle. `wb_stall` does not mask it.
- No data path bypass: the register file sees the write exactly one cycle after the handshake.

## Timing
- Reset values: `we`=0, `wa`=0, `wd`=0, `conflict`=0, `ptr`=0.
- While `reset` is high, `req_ready`=0.
- Reset asserted mid-operation: a write already registered into `we`/`wa`/`wd` is dropped; `we` clears asynchronously.
- Latency: a transfer at edge N makes `we`=1 visible from edge N to edge N+1. The register file captures the data at edge N+1.
- Throughput: one transfer per cycle, sustained.
- Fairness: with all NREQ requesters continuously valid, each is granted exactly once in every NREQ consecutive cycles.
- `wb_stall` rising in the same cycle as a valid request: no grant, and `ptr` is unchanged.
- First cycle after reset release: `ptr`=0, so requester 0 wins any tie.

## Structure
- Shared package `rf_pkg` holds:
  - `RF_AW`=5, `RF_DW`=32, `RF_NREGS`=32, `RF_ZERO_REG`=0.
  - typedef `rf_addr_t` (logic [4:0]) and typedef `rf_data_t` (logic [31:0]).
- Sub-module `rr_pick`:
  - Purely combinational.
  - Inputs: request vector and pointer. Outputs: one-hot grant and encoded index.
  - Instantiated once.
- The top level holds `ptr`, the output registers and `conflict`.

## Test plan
- Reset then single request: requester 1 valid with wa=5, wd=0xDEADBEEF → `req_ready`=0b10 immediately. Next cycle: `we`=1, `wa`=5, `wd`=0xDEADBEEF. The cycle after: `we`=0.
- Tie after reset: NREQ=2, both requesters valid continuously with distinct data → grants alternate 0,1,0,1. `conflict`=1 from the second cycle onward. `we` stays high throughout.
- Zero-register write: requester 0 valid with wa=0, wd=0x1234 → `req_ready[0]`=1 and `ptr` moves to 1. Next cycle `we`=0.
- Stall: `wb_stall`=1 for 3 cycles while requester 0 is valid → `req_ready`=0 and `we`=0 for those cycles. The grant occurs in the first cycle after `wb_stall` drops.
- Reset mid-operation: assert `reset` the cycle after a transfer to wa=7 → `we` drops asynchronously, and `ptr`=0 after release.
- NREQ=4 rotation: all four requesters valid for 8 cycles → grant sequence 0,1,2,3,0,1,2,3. Each requester is granted exactly twice.

Source files
------------

// File: rtl/rf_write_arbiter_pkg.sv
// Shared register-file constants and types used by the writeback arbiter.
package rf_pkg;

    localparam int RF_AW       = 5;
    localparam int RF_DW       = 32;
    localparam int RF_NREGS    = 32;
    localparam int RF_ZERO_REG = 0;

    typedef logic [RF_AW-1:0] rf_addr_t;
    typedef logic [RF_DW-1:0] rf_data_t;

endpackage

// File: rtl/rf_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            any
);

    logic [2*NREQ-1:0] dbl;
    logic [IW:0]       sum;

    // Rotating the doubled vector right by ptr puts the search start at bit 0.
    assign dbl = {req, req} >> ptr;

    always_comb begin
        any = 1'b0;
        idx = '0;
        sum = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!any && dbl[i]) begin
                any = 1'b1;
                sum = {1'b0, ptr} + (IW+1)'(i);
                if (sum >= (IW+1)'(NREQ))
                    sum = sum - (IW+1)'(NREQ);
                idx = sum[IW-1:0];
            end
        end
        gnt = '0;
        for (int j = 0; j < NREQ; j++)
            gnt[j] = any && (idx == IW'(j));
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NREQ writeback
// requesters; the winning write is registered and presented one cycle later.
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int DW   = 32,
    parameter int AW   = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wb_stall,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*AW-1:0]  req_wa,
    input  logic [NREQ*DW-1:0]  req_wd,
    output logic [NREQ-1:0]     req_ready,
    output logic                we,
    output logic [AW-1:0]       wa,
    output logic [DW-1:0]       wd,
    output logic                conflict
);

    localparam int IW = $clog2(NREQ);

    logic [IW-1:0]   ptr_q, ptr_d;
    logic            we_q, we_d;
    logic [AW-1:0]   wa_q, wa_d;
    logic [DW-1:0]   wd_q, wd_d;
    logic            conflict_q, conflict_d;

    logic [NREQ-1:0] pick_gnt;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic            xfer;
    logic [AW-1:0]   win_wa;
    logic [DW-1:0]   win_wd;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req  (req_valid),
        .ptr  (ptr_q),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // Grants are gated here so the picker stays a pure function of valid and ptr.
    assign req_ready = (reset || wb_stall) ? '0 : pick_gnt;
    assign xfer      = pick_any && !reset && !wb_stall;

    always_comb begin
        win_wa = '0;
        win_wd = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == IW'(i)) begin
                win_wa = req_wa[i*AW +: AW];
                win_wd = req_wd[i*DW +: DW];
            end
        end
    end

    always_comb begin
        ptr_d      = ptr_q;
        we_d       = 1'b0;
        wa_d       = wa_q;
        wd_d       = wd_q;
        conflict_d = ($countones(req_valid) >= 2);
        if (xfer) begin
            ptr_d = (pick_idx == IW'(NREQ-1)) ? '0 : pick_idx + IW'(1);
            wa_d  = win_wa;
            wd_d  = win_wd;
            // Writes to the zero register are consumed but never reach the file.
            we_d  = (win_wa != AW'(RF_ZERO_REG));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q      <= '0;
            we_q       <= 1'b0;
            wa_q       <= '0;
            wd_q       <= '0;
            conflict_q <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            we_q       <= we_d;
            wa_q       <= wa_d;
            wd_q       <= wd_d;
            conflict_q <= conflict_d;
        end
    end

    assign we       = we_q;
    assign wa       = wa_q;
    assign wd       = wd_q;
    assign conflict = conflict_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: a 2-requester and a 4-requester instance.
module tb_rf_write_arbiter;

    logic         clk;
    logic         reset;
    logic         wb_stall;

    logic [1:0]   req_valid;
    logic [9:0]   req_wa;
    logic [63:0]  req_wd;
    logic [1:0]   req_ready;
    logic         we;
    logic [4:0]   wa;
    logic [31:0]  wd;
    logic         conflict;

    logic [3:0]   req_valid4;
    logic [19:0]  req_wa4;
    logic [127:0] req_wd4;
    logic [3:0]   req_ready4;
    logic         we4;
    logic [4:0]   wa4;
    logic [31:0]  wd4;
    logic         conflict4;

    int errors;
    int checks;

    rf_write_arbiter #(.NREQ(2), .DW(32), .AW(5)) dut2 (
        .clk       (clk),
        .reset     (reset),
        .wb_stall  (wb_stall),
        .req_valid (req_valid),
        .req_wa    (req_wa),
        .req_wd    (req_wd),
        .req_ready (req_ready),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .conflict  (conflict)
    );

    rf_write_arbiter #(.NREQ(4), .DW(32), .AW(5)) dut4 (
        .clk       (clk),
        .reset     (reset),
        .wb_stall  (1'b0),
        .req_valid (req_valid4),
        .req_wa    (req_wa4),
        .req_wd    (req_wd4),
        .req_ready (req_ready4),
        .we        (we4),
        .wa        (wa4),
        .wd        (wd4),
        .conflict  (conflict4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wb_stall = 1'b0;
        req_valid = 2'b11;
        req_wa = '0;
        req_wd = '0;
        req_valid4 = '0;
        req_wa4 = '0;
        req_wd4 = '0;
        step();
        step();
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", we); end
        checks++; if (wa !== 5'd0 || wd !== 32'd0) begin errors++; $display("FAIL reset_wa_wd got=%0d/%h exp=0/0", wa, wd); end
        checks++; if (conflict !== 1'b0) begin errors++; $display("FAIL reset_conflict got=%b exp=0", conflict); end
        req_valid = 2'b00;
        reset = 1'b0;
        step();
    endtask

    task automatic test_single();
        req_valid = 2'b10;
        req_wa[9:5] = 5'd5;
        req_wd[63:32] = 32'hDEADBEEF;
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL single_ready got=%b exp=10", req_ready); end
        step();
        req_valid = 2'b00;
        #1;
        checks++; if (we !== 1'b1 || wa !== 5'd5 || wd !== 32'hDEADBEEF)
            begin errors++; $display("FAIL single_write got=%b/%0d/%h exp=1/5/deadbeef", we, wa, wd); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL single_idle_ready got=%b exp=00", req_ready); end
        step();
        checks++; if (we !== 1'b0 || wa !== 5'd5) begin errors++; $display("FAIL single_we_drop got=%b/%0d exp=0/5", we, wa); end
    endtask

    task automatic test_tie();
        logic [1:0]  exp_rdy;
        logic [4:0]  exp_wa;
        logic [31:0] exp_wd;
        req_wa = {5'd2, 5'd1};
        req_wd = {32'hB1B1B1B1, 32'hA0A0A0A0};
        req_valid = 2'b11;
        #1;
        checks++; if (conflict !== 1'b0) begin errors++; $display("FAIL tie_conflict_start got=%b exp=0", conflict); end
        for (int i = 0; i < 4; i++) begin
            exp_rdy = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_wa  = (i % 2 == 0) ? 5'd1 : 5'd2;
            exp_wd  = (i % 2 == 0) ? 32'hA0A0A0A0 : 32'hB1B1B1B1;
            checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL tie_ready[%0d] got=%b exp=%b", i, req_ready, exp_rdy); end
            step();
            checks++; if (we !== 1'b1 || wa !== exp_wa || wd !== exp_wd)
                begin errors++; $display("FAIL tie_write[%0d] got=%b/%0d/%h exp=1/%0d/%h", i, we, wa, wd, exp_wa, exp_wd); end
            checks++; if (conflict !== 1'b1) begin errors++; $display("FAIL tie_conflict[%0d] got=%b exp=1", i, conflict); end
        end
        req_valid = 2'b00;
        step();
    endtask

    task automatic test_zero_reg();
        req_wa = {5'd9, 5'd0};
        req_wd = {32'h00009999, 32'h00001234};
        req_valid = 2'b01;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL zero_ready got=%b exp=01", req_ready); end
        step();
        checks++; if (we !== 1'b0 || wa !== 5'd0 || wd !== 32'h00001234)
            begin errors++; $display("FAIL zero_write got=%b/%0d/%h exp=0/0/00001234", we, wa, wd); end
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL zero_ptr_moved got=%b exp=10", req_ready); end
        step();
        req_valid = 2'b00;
        #1;
        checks++; if (we !== 1'b1 || wa !== 5'd9) begin errors++; $display("FAIL zero_next_write got=%b/%0d exp=1/9", we, wa); end
        step();
    endtask

    task automatic test_stall();
        req_wa = {5'd4, 5'd3};
        req_wd = {32'h44, 32'h33};
        wb_stall = 1'b1;
        req_valid = 2'b11;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL stall_ready[%0d] got=%b exp=00", i, req_ready); end
            step();
            checks++; if (we !== 1'b0) begin errors++; $display("FAIL stall_we[%0d] got=%b exp=0", i, we); end
            checks++; if (conflict !== 1'b1) begin errors++; $display("FAIL stall_conflict[%0d] got=%b exp=1", i, conflict); end
        end
        wb_stall = 1'b0;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL stall_release_ready got=%b exp=01", req_ready); end
        step();
        req_valid = 2'b00;
        #1;
        checks++; if (we !== 1'b1 || wa !== 5'd3 || wd !== 32'h33)
            begin errors++; $display("FAIL stall_release_write got=%b/%0d/%h exp=1/3/33", we, wa, wd); end
        step();
    endtask

    task automatic test_reset_mid();
        // ptr is 1 here; a lone request from 0 still wins.
        req_wa = {5'd8, 5'd7};
        req_wd = {32'h88, 32'h77};
        req_valid = 2'b01;
        step();
        checks++; if (we !== 1'b1 || wa !== 5'd7) begin errors++; $display("FAIL mid_write got=%b/%0d exp=1/7", we, wa); end
        reset = 1'b1;
        #1;
        checks++; if (we !== 1'b0 || wa !== 5'd0) begin errors++; $display("FAIL mid_async_clear got=%b/%0d exp=0/0", we, wa); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL mid_ready_in_reset got=%b exp=00", req_ready); end
        step();
        reset = 1'b0;
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL mid_ptr_after_reset got=%b exp=01", req_ready); end
        step();
        req_valid = 2'b00;
        #1;
        checks++; if (we !== 1'b1 || wa !== 5'd7) begin errors++; $display("FAIL mid_post_write got=%b/%0d exp=1/7", we, wa); end
        step();
    endtask

    task automatic test_rot4();
        int cnt [4];
        logic [3:0] exp_rdy;
        logic [4:0] exp_wa;
        for (int k = 0; k < 4; k++) cnt[k] = 0;
        req_wa4 = {5'd14, 5'd13, 5'd12, 5'd11};
        req_wd4 = {32'h3333, 32'h2222, 32'h1111, 32'h0000};
        req_valid4 = 4'b1111;
        #1;
        for (int i = 0; i < 8; i++) begin
            exp_rdy = 4'b0001 << (i % 4);
            exp_wa  = 5'd11 + 5'(i % 4);
            checks++; if (req_ready4 !== exp_rdy) begin errors++; $display("FAIL rot4_ready[%0d] got=%b exp=%b", i, req_ready4, exp_rdy); end
            for (int k = 0; k < 4; k++) if (req_ready4[k]) cnt[k]++;
            step();
            checks++; if (we4 !== 1'b1 || wa4 !== exp_wa) begin errors++; $display("FAIL rot4_write[%0d] got=%b/%0d exp=1/%0d", i, we4, wa4, exp_wa); end
        end
        for (int k = 0; k < 4; k++) begin
            checks++; if (cnt[k] !== 2) begin errors++; $display("FAIL rot4_count[%0d] got=%0d exp=2", k, cnt[k]); end
        end
        checks++; if (conflict4 !== 1'b1) begin errors++; $display("FAIL rot4_conflict got=%b exp=1", conflict4); end
        req_valid4 = 4'b0000;
        step();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_single();
        test_tie();
        test_zero_reg();
        test_stall();
        test_reset_mid();
        test_rot4();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
